// File: rtl/fpu_burst_writer_if.sv
// DRAM-side bus of the FPU burst writer: burst request, line data and
// the beat / burst-complete handshake coming back from the DRAM controller.
interface fpu_burst_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 64,
  parameter int MAX_BURST  = 8
);
  logic                       dram_request;
  logic [ADDR_WIDTH-1:0]      dram_address;
  logic [$clog2(MAX_BURST):0] dram_request_size;
  logic [8*LINE_BYTES-1:0]    write_data;
  logic                       fpu_ready;
  logic                       dram_ready;
  logic                       request_done;

  // Writer side: issues requests and presents lines.
  modport master (
    output dram_request,
    output dram_address,
    output dram_request_size,
    output write_data,
    output fpu_ready,
    input  dram_ready,
    input  request_done
  );

  // DRAM side: accepts beats and reports burst completion.
  modport slave (
    input  dram_request,
    input  dram_address,
    input  dram_request_size,
    input  write_data,
    input  fpu_ready,
    output dram_ready,
    output request_done
  );
endinterface

// File: rtl/fpu_burst_writer.sv
// DRAM write-back engine: drains a width x height byte region of the
// column-organised request buffer, packs each row into LINE_BYTES lines
// and issues them as bursts of up to MAX_BURST lines with a row stride.
module fpu_burst_writer #(
  parameter int BUFFER_DEPTH = 512,
  parameter int ROWS         = 8,
  parameter int LINE_BYTES   = 64,
  parameter int MAX_BURST    = 8,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [ADDR_WIDTH-1:0]                        base_address,
  input  logic [ADDR_WIDTH-1:0]                        stride,
  input  logic [15:0]                                  width,
  input  logic [15:0]                                  height,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         cmd_error,
  output logic [$clog2(BUFFER_DEPTH)+$clog2(ROWS)-1:0] buf_rd_addr,
  input  logic [7:0]                                   buf_rd_data,
  fpu_burst_writer_if.master                           dram
);

  localparam int COL_W   = $clog2(BUFFER_DEPTH);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int LB_LOG  = $clog2(LINE_BYTES);
  localparam int SIZE_W  = $clog2(MAX_BURST) + 1;
  localparam int LINE_W  = 8 * LINE_BYTES;
  localparam int FILL_W  = LB_LOG + 1;
  localparam int COLC_W  = 17 + LB_LOG;

  localparam logic [15:0]       DEPTH16   = 16'(BUFFER_DEPTH);
  localparam logic [15:0]       ROWS16    = 16'(ROWS);
  localparam logic [16:0]       MAXB17    = 17'(MAX_BURST);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LINE_BYTES);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK     = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_FIN       = 3'd6;

  logic [2:0]            state_reg;
  logic [ADDR_WIDTH-1:0] row_base_reg;      // DRAM address of byte 0 of the current row
  logic [ADDR_WIDTH-1:0] stride_reg;
  logic [15:0]           width_reg;
  logic [15:0]           height_reg;
  logic [15:0]           row_reg;
  logic [16:0]           line_reg;          // line index within the current row
  logic [16:0]           lines_per_row_reg;
  logic [SIZE_W-1:0]     beat_reg;          // line index within the current burst
  logic [FILL_W-1:0]     fill_reg;          // read slot within the line being filled
  logic                  rd_valid_reg;      // byte returning this cycle lies inside the row
  logic                  done_hold_reg;     // request_done seen before WAIT_DONE
  logic [LINE_W-1:0]     line_data_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [SIZE_W-1:0]     size_reg;

  logic                  cmd_illegal;
  logic                  cmd_empty;
  logic [16:0]           width_round;
  logic [16:0]           lines_calc;
  logic [COLC_W-1:0]     col_calc;

  // Lines in the next burst: the remainder of the row, capped at MAX_BURST.
  function automatic logic [SIZE_W-1:0] burst_len(input logic [16:0] remaining);
    if (remaining > MAXB17) begin
      return SIZE_W'(MAX_BURST);
    end
    return remaining[SIZE_W-1:0];
  endfunction

  // Byte offset of a line within its row.
  function automatic logic [ADDR_WIDTH-1:0] line_offset(input logic [16:0] line);
    return ADDR_WIDTH'(line) << LB_LOG;
  endfunction

  assign cmd_illegal = (width_reg > DEPTH16) || (height_reg > ROWS16);
  assign cmd_empty   = (width_reg == 16'd0) || (height_reg == 16'd0);
  assign width_round = {1'b0, width_reg} + 17'(LINE_BYTES - 1);
  assign lines_calc  = width_round >> LB_LOG;
  assign col_calc    = (COLC_W'(line_reg) << LB_LOG) + COLC_W'(fill_reg);

  assign busy      = (state_reg != S_IDLE) && (state_reg != S_FIN);
  assign done      = (state_reg == S_FIN);
  assign cmd_error = (state_reg == S_CHECK) && cmd_illegal;

  // Buffer address is only driven while reading so it rests at zero.
  assign buf_rd_addr = (state_reg == S_FILL) ?
                       {col_calc[COL_W-1:0], row_reg[ROW_W-1:0]} : '0;

  assign dram.dram_request      = (state_reg == S_REQ);
  assign dram.dram_address      = addr_reg;
  assign dram.dram_request_size = size_reg;
  assign dram.write_data        = line_data_reg;
  assign dram.fpu_ready         = (state_reg == S_SEND);

  // Command sequencer: validate, then per row walk bursts, per burst fill and send lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= S_IDLE;
      row_base_reg      <= '0;
      stride_reg        <= '0;
      width_reg         <= '0;
      height_reg        <= '0;
      row_reg           <= '0;
      line_reg          <= '0;
      lines_per_row_reg <= '0;
      beat_reg          <= '0;
      fill_reg          <= '0;
      rd_valid_reg      <= 1'b0;
      done_hold_reg     <= 1'b0;
      line_data_reg     <= '0;
      addr_reg          <= '0;
      size_reg          <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            row_base_reg <= base_address;
            stride_reg   <= stride;
            width_reg    <= width;
            height_reg   <= height;
            state_reg    <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cmd_illegal) begin
            state_reg <= S_IDLE;
          end else if (cmd_empty) begin
            state_reg <= S_FIN;
          end else begin
            row_reg           <= '0;
            line_reg          <= '0;
            lines_per_row_reg <= lines_calc;
            addr_reg          <= row_base_reg;
            size_reg          <= burst_len(lines_calc);
            state_reg         <= S_REQ;
          end
        end

        S_REQ: begin
          fill_reg      <= '0;
          beat_reg      <= '0;
          done_hold_reg <= 1'b0;
          state_reg     <= S_FILL;
        end

        // Slot 0..LINE_BYTES-1 issues reads; each following slot shifts in the
        // byte returned for the previous read, so one extra slot drains the pipe.
        S_FILL: begin
          done_hold_reg <= done_hold_reg | dram.request_done;
          rd_valid_reg  <= (col_calc < COLC_W'(width_reg));
          if (fill_reg != '0) begin
            line_data_reg <= {line_data_reg[LINE_W-9:0],
                              (rd_valid_reg ? buf_rd_data : 8'h00)};
          end
          if (fill_reg == FILL_LAST) begin
            state_reg <= S_SEND;
          end else begin
            fill_reg <= fill_reg + FILL_W'(1);
          end
        end

        S_SEND: begin
          done_hold_reg <= done_hold_reg | dram.request_done;
          if (dram.dram_ready) begin
            line_reg <= line_reg + 17'd1;
            if (beat_reg == size_reg - SIZE_W'(1)) begin
              state_reg <= S_WAIT_DONE;
            end else begin
              beat_reg  <= beat_reg + SIZE_W'(1);
              fill_reg  <= '0;
              state_reg <= S_FILL;
            end
          end
        end

        S_WAIT_DONE: begin
          if (dram.request_done || done_hold_reg) begin
            done_hold_reg <= 1'b0;
            if (line_reg < lines_per_row_reg) begin
              addr_reg  <= row_base_reg + line_offset(line_reg);
              size_reg  <= burst_len(lines_per_row_reg - line_reg);
              state_reg <= S_REQ;
            end else if ((row_reg + 16'd1) < height_reg) begin
              row_reg      <= row_reg + 16'd1;
              row_base_reg <= row_base_reg + stride_reg;
              line_reg     <= '0;
              addr_reg     <= row_base_reg + stride_reg;
              size_reg     <= burst_len(lines_per_row_reg);
              state_reg    <= S_REQ;
            end else begin
              state_reg <= S_FIN;
            end
          end
        end

        S_FIN: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_burst_writer.sv
// Bench for fpu_burst_writer: random buffer contents, a DRAM responder with
// random stalls, and a reference model of the expected bursts and DRAM image.
module tb_fpu_burst_writer;
  localparam int BD   = 512;
  localparam int RW   = 8;
  localparam int LB   = 64;
  localparam int MB   = 8;
  localparam int AW   = 32;
  localparam int BA_W = $clog2(BD) + $clog2(RW);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_address = '0;
  logic [AW-1:0]   stride = '0;
  logic [15:0]     width = '0;
  logic [15:0]     height = '0;
  logic            busy, done, cmd_error;
  logic [BA_W-1:0] buf_rd_addr;
  logic [7:0]      buf_rd_data;

  fpu_burst_writer_if #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .MAX_BURST(MB)) dram ();

  fpu_burst_writer #(
    .BUFFER_DEPTH(BD), .ROWS(RW), .LINE_BYTES(LB), .MAX_BURST(MB), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_address(base_address), .stride(stride), .width(width), .height(height),
    .busy(busy), .done(done), .cmd_error(cmd_error),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .dram(dram)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Request buffer: {column, row} addressing, one-cycle read latency.
  logic [7:0] bufm [0:BD*RW-1];
  always @(posedge clk) buf_rd_data <= bufm[buf_rd_addr];

  logic [7:0] mem [logic [31:0]];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return {1'b1, mem[a]};
    return 9'h0;
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  size;
  } req_t;
  req_t exp_q[$];
  int   exp_n;

  // Expected burst list: every row split into MAX_BURST-line chunks.
  task automatic build_model(input logic [31:0] b, input logic [31:0] s, input int w, input int h);
    int L;
    req_t e;
    exp_q.delete();
    if (w > 0 && h > 0 && w <= BD && h <= RW) begin
      L = (w + LB - 1) / LB;
      for (int r = 0; r < h; r++) begin
        for (int k = 0; k < L; k += MB) begin
          e.addr = b + s * r + k * LB;
          e.size = 4'((L - k > MB) ? MB : L - k);
          exp_q.push_back(e);
        end
      end
    end
    exp_n = exp_q.size();
  endtask

  // ---------------- monitor ----------------
  bit   mon_en = 1'b0;
  int   t0 = 0;
  int   n_req, n_done, n_err, n_rdy;
  int   t_req, t_rdy, t_done, t_err;
  logic busy1, busy2;

  initial begin : monitor
    int   rel;
    req_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        rel = cyc - t0 + 1;
        if (rel == 1) busy1 = busy;
        if (rel == 2) busy2 = busy;
        if (dram.dram_request) begin
          n_req++;
          if (t_req < 0) t_req = rel;
          if (exp_q.size() == 0) begin
            chk("req_count_overrun", 64'(n_req), 64'(exp_n));
          end else begin
            e = exp_q.pop_front();
            chk("req_addr", 64'(dram.dram_address), 64'(e.addr));
            chk("req_size", 64'(dram.dram_request_size), 64'(e.size));
          end
        end
        if (dram.fpu_ready) begin
          n_rdy++;
          if (t_rdy < 0) t_rdy = rel;
        end
        if (done) begin
          n_done++;
          t_done = rel;
        end
        if (cmd_error) begin
          n_err++;
          t_err = rel;
        end
      end
    end
  end

  // ---------------- DRAM responder ----------------
  int               max_stall = 0;
  bit               hold_at2 = 1'b0;
  int               resp_beats = 0;
  logic [8*LB-1:0]  prev_wd;

  initial begin : responder
    bit          active;
    bit          have_prev;
    logic [31:0] cur_addr;
    int          cur_size;
    int          wait_cnt;
    int          done_dly;
    active = 0; have_prev = 0; wait_cnt = 0; done_dly = -1; cur_size = 0; cur_addr = '0;
    dram.dram_ready   = 1'b0;
    dram.request_done = 1'b0;
    forever begin
      @(negedge clk);
      dram.request_done = 1'b0;
      if (!rst_n) begin
        active = 0; have_prev = 0; wait_cnt = 0; done_dly = -1; resp_beats = 0;
        dram.dram_ready = 1'b0;
      end else begin
        if (have_prev) begin
          chk("stall_ready_held", 64'(dram.fpu_ready), 64'd1);
          chk("stall_data_held", 64'(dram.write_data == prev_wd), 64'd1);
        end
        have_prev = 0;
        if (dram.dram_request) begin
          active = 1; cur_addr = dram.dram_address;
          cur_size = int'(dram.dram_request_size); resp_beats = 0;
        end
        if (dram.fpu_ready) begin
          if (!active) begin
            chk("beat_inside_burst", 64'(active), 64'd1);
            dram.dram_ready = 1'b0;
          end else if (wait_cnt > 0 || (hold_at2 && resp_beats == 2)) begin
            if (wait_cnt > 0) wait_cnt--;
            dram.dram_ready = 1'b0;
            have_prev = 1;
            prev_wd = dram.write_data;
          end else begin
            dram.dram_ready = 1'b1;
            for (int b = 0; b < LB; b++)
              mem[cur_addr + 32'(resp_beats * LB + b)] = dram.write_data[8*LB-1-8*b -: 8];
            resp_beats++;
            wait_cnt = $urandom_range(0, max_stall);
            if (resp_beats == cur_size) begin
              active = 0;
              if ($urandom_range(0, 3) == 0) dram.request_done = 1'b1;
              else done_dly = $urandom_range(1, 4);
            end
          end
        end else begin
          dram.dram_ready = 1'($urandom_range(0, 1));
        end
        if (done_dly > 0) begin
          done_dly--;
          if (done_dly == 0) begin
            dram.request_done = 1'b1;
            done_dly = -1;
          end
        end
      end
    end
  end

  // ---------------- command helpers ----------------
  task automatic launch(input logic [31:0] b, input logic [31:0] s, input int w, input int h);
    mem.delete();
    n_req = 0; n_done = 0; n_err = 0; n_rdy = 0;
    t_req = -1; t_rdy = -1; t_done = -1; t_err = -1;
    busy1 = 1'bx; busy2 = 1'bx;
    @(negedge clk); #1;
    base_address = b; stride = s; width = 16'(w); height = 16'(h); start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (n_done == 0 && n_err == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("cmd_completes", 64'((n_done + n_err) > 0), 64'd1);
    repeat (4) begin
      @(negedge clk); #1;
    end
    mon_en = 1'b0;
  endtask

  task automatic check_legal(input string tag);
    chk("req_count", 64'(n_req), 64'(exp_n));
    chk("req_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_once", 64'(n_done), 64'd1);
    chk("no_cmd_error", 64'(n_err), 64'd0);
    chk("busy_cycle1", 64'(busy1), 64'd1);
    chk("first_request_cycle", 64'(t_req), 64'd2);
    chk("first_ready_cycle", 64'(t_rdy), 64'(LB + 4));
    $display("cmd %s: requests=%0d beats=%0d done_cycle=%0d", tag, n_req, n_rdy, t_done);
  endtask

  task automatic check_image(input logic [31:0] b, input logic [31:0] s, input int w, input int h);
    int          L, mism, col;
    logic [31:0] a;
    logic [7:0]  ev;
    L = (w + LB - 1) / LB;
    mism = 0;
    for (int r = 0; r < h; r++)
      for (int j = 0; j < L; j++)
        for (int bb = 0; bb < LB; bb++) begin
          col = j * LB + bb;
          a   = b + s * r + 32'(col);
          ev  = (col < w) ? bufm[col*RW + r] : 8'h00;
          if (rd_mem(a) !== {1'b1, ev}) mism++;
        end
    chk("image_mismatches", 64'(mism), 64'd0);
    chk("image_bytes", 64'(mem.size()), 64'(h * L * LB));
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cmd_error", 64'(cmd_error), 64'd0);
    chk("rst_dram_request", 64'(dram.dram_request), 64'd0);
    chk("rst_fpu_ready", 64'(dram.fpu_ready), 64'd0);
    chk("rst_dram_address", 64'(dram.dram_address), 64'd0);
    chk("rst_request_size", 64'(dram.dram_request_size), 64'd0);
    chk("rst_write_data_zero", 64'(dram.write_data == '0), 64'd1);
    chk("rst_buf_rd_addr", 64'(buf_rd_addr), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] rb, rs;
    int          rw, rh, n;

    for (int i = 0; i < BD * RW; i++) bufm[i] = 8'($urandom);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Full default region with long DRAM stalls.
    max_stall = 10;
    build_model(32'h0, 32'd512, 512, 8);
    launch(32'h0, 32'd512, 512, 8);
    wait_end(20000);
    check_legal("full");
    check_image(32'h0, 32'd512, 512, 8);

    // Partial last line, large stride.
    max_stall = 3;
    build_model(32'h100, 32'd4096, 100, 3);
    chk("model_req0_addr", 64'(exp_q[0].addr), 64'h100);
    chk("model_req1_addr", 64'(exp_q[1].addr), 64'h1100);
    chk("model_req2_addr", 64'(exp_q[2].addr), 64'h2100);
    chk("model_req0_size", 64'(exp_q[0].size), 64'd2);
    launch(32'h100, 32'd4096, 100, 3);
    wait_end(5000);
    check_legal("w100");
    check_image(32'h100, 32'd4096, 100, 3);
    chk("pad_row0_byte100", 64'(rd_mem(32'h100 + 32'd100)), 64'h100);
    chk("pad_row2_byte127", 64'(rd_mem(32'h2100 + 32'd127)), 64'h100);
    chk("row1_byte99", 64'(rd_mem(32'h1100 + 32'd99)), 64'({1'b1, bufm[99*RW + 1]}));

    // Illegal width.
    build_model(32'h0, 32'd512, 1024, 1);
    launch(32'h0, 32'd512, 1024, 1);
    wait_end(50);
    chk("err_cycle", 64'(t_err), 64'd1);
    chk("err_count", 64'(n_err), 64'd1);
    chk("err_no_request", 64'(n_req), 64'd0);
    chk("err_no_done", 64'(n_done), 64'd0);
    chk("err_busy_cycle2", 64'(busy2), 64'd0);
    $display("cmd illegal: error_cycle=%0d requests=%0d", t_err, n_req);

    // Zero-width command.
    build_model(32'h0, 32'd512, 0, 5);
    launch(32'h0, 32'd512, 0, 5);
    wait_end(50);
    chk("zero_done_cycle", 64'(t_done), 64'd2);
    chk("zero_done_count", 64'(n_done), 64'd1);
    chk("zero_no_request", 64'(n_req), 64'd0);
    chk("zero_no_ready", 64'(n_rdy), 64'd0);
    $display("cmd empty: done_cycle=%0d requests=%0d", t_done, n_req);

    // Address wrap at the top of the DRAM space.
    build_model(32'hFFFF_FFC0, 32'd512, 128, 1);
    chk("model_wrap_addr", 64'(exp_q[0].addr), 64'hFFFF_FFC0);
    chk("model_wrap_size", 64'(exp_q[0].size), 64'd2);
    launch(32'hFFFF_FFC0, 32'd512, 128, 1);
    wait_end(2000);
    check_legal("wrap");
    check_image(32'hFFFF_FFC0, 32'd512, 128, 1);
    chk("wrap_first_byte", 64'(rd_mem(32'hFFFF_FFC0)), 64'({1'b1, bufm[0]}));
    chk("wrap_second_line", 64'(rd_mem(32'h0)), 64'({1'b1, bufm[64*RW]}));

    // Random legal commands.
    for (int t = 0; t < 3; t++) begin
      rw = $urandom_range(1, BD);
      rh = $urandom_range(1, RW);
      rb = $urandom;
      rs = 32'($urandom_range(8, 16) * 64);
      build_model(rb, rs, rw, rh);
      launch(rb, rs, rw, rh);
      wait_end(20000);
      check_legal($sformatf("rand%0d w=%0d h=%0d", t, rw, rh));
      check_image(rb, rs, rw, rh);
    end

    // Reset while the third beat of a burst is pending.
    max_stall = 0;
    hold_at2 = 1'b1;
    build_model(32'h0, 32'd512, 512, 1);
    launch(32'h0, 32'd512, 512, 1);
    n = 0;
    while (!(resp_beats == 2 && dram.fpu_ready) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reached_third_beat", 64'(resp_beats == 2 && dram.fpu_ready), 64'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs();
    rst_n = 1'b1;
    hold_at2 = 1'b0;
    $display("cmd reset_abort: beats_before_reset=%0d", resp_beats);

    // Fresh command after the abort.
    max_stall = 2;
    build_model(32'h4000, 32'd1024, 200, 2);
    launch(32'h4000, 32'd1024, 200, 2);
    wait_end(5000);
    check_legal("after_reset");
    check_image(32'h4000, 32'd1024, 200, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
